dmem_line_responder: RTL and testbench

//   Memory-side responder for the dcache line-transfer interface (enable/write/addr/data/ack).

---
 rtl/mem_if_pkg.sv | 15 +
 rtl/dmem_line_responder.sv | 109 ++++++++++
 tb/tb_dmem_line_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared line-transfer interface constants and responder state type
package mem_if_pkg;

    localparam int ADDR_W           = 32;
    localparam int LINE_W           = 256;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int INDEX_BITS       = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_line_responder.sv
// rtl/dmem_line_responder.sv - fixed-latency line-store responder for the dcache line interface
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-low reset (line store is not reset)
//   addr_i    byte address; line index taken from bits above the line offset
//   data_i    write line
//   enable_i  request valid, level, held by the initiator until ack
//   write_i   1 = write line, 0 = read line, sampled with enable_i
//   ack_o     one-cycle registered completion pulse
//   data_o    read line, valid in the ack cycle of a read, held until the next read ack
module dmem_line_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [7:0]  LAT_INIT = 8'(LATENCY - 1);

    logic [LINE_W-1:0] memory [0:DEPTH-1];

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_count;
    logic [IDX_W-1:0]  r_index;
    logic              r_write;
    logic [LINE_W-1:0] r_wdata;
    logic              r_ack;
    logic [LINE_W-1:0] r_rdata;

    logic              w_enter_ack;
    logic [IDX_W-1:0]  w_idx;
    logic              w_wr;
    logic [LINE_W-1:0] w_wd;
    logic              w_unused;

    // Address bits outside the line index are ignored (offset and alias bits).
    assign w_unused = ^{addr_i[ADDR_W-1:LINE_OFFSET_BITS+IDX_W], addr_i[LINE_OFFSET_BITS-1:0]};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (enable_i) w_next = (LATENCY == 1) ? ACK : BUSY;
            BUSY:    if (r_count <= 8'd1) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_enter_ack = (w_next == ACK);

    // With LATENCY==1 the ACK transition happens on the capture edge itself,
    // so the request fields come straight from the inputs rather than the latch.
    assign w_idx = (r_state == IDLE) ? addr_i[LINE_OFFSET_BITS +: IDX_W] : r_index;
    assign w_wr  = (r_state == IDLE) ? write_i : r_write;
    assign w_wd  = (r_state == IDLE) ? data_i  : r_wdata;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_count <= 8'd0;
            r_index <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_enter_ack;
            if (r_state == IDLE && enable_i) begin
                r_count <= LAT_INIT;
                r_index <= addr_i[LINE_OFFSET_BITS +: IDX_W];
                r_write <= write_i;
                r_wdata <= data_i;
            end else if (r_state == BUSY) begin
                r_count <= r_count - 8'd1;
            end
            if (w_enter_ack && !w_wr) begin
                r_rdata <= memory[w_idx];
            end
        end
    end

    // Gated by rst_i so a request interrupted by reset never commits.
    always_ff @(posedge clk_i) begin
        if (rst_i && w_enter_ack && w_wr) begin
            memory[w_idx] <= w_wd;
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_rdata;

    a_enable_known : assert property (@(posedge clk_i) disable iff (!rst_i)
        (r_state == IDLE) |-> !$isunknown(enable_i))
        else $error("enable_i unknown while idle");

endmodule

// File: tb/tb_dmem_line_responder.sv
// tb/tb_dmem_line_responder.sv - scoreboard bench for dmem_line_responder
module tb_dmem_line_responder;

    typedef struct {
        int           cyc;
        logic [255:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  addr;
    logic [255:0] din;
    logic         write;
    logic         en0, en1;
    logic         ack0, ack1;
    logic [255:0] dout0, dout1;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int acks0  = 0;
    int acks1  = 0;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [255:0] ref_mem [2][512];
    logic [255:0] last_rd [2];

    dmem_line_responder #(.DEPTH(512), .LATENCY(10)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(din),
        .enable_i(en0), .write_i(write), .ack_o(ack0), .data_o(dout0)
    );

    dmem_line_responder #(.DEPTH(512), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(din),
        .enable_i(en1), .write_i(write), .ack_o(ack1), .data_o(dout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] dmem(input int w, input int idx);
        return (w == 0) ? dut0.memory[idx] : dut1.memory[idx];
    endfunction

    // Monitors: every ack pops one expected completion and checks cycle and data.
    always @(negedge clk) begin
        if (rst_n && ack0) begin
            if (q0.size() == 0) begin
                chk_int("dut0_unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk_int("dut0_ack_cycle", cyc, e.cyc);
                chk("dut0_data_o", dout0, e.data);
            end
            acks0++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && ack1) begin
            if (q1.size() == 0) begin
                chk_int("dut1_unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk_int("dut1_ack_cycle", cyc, e.cyc);
                chk("dut1_data_o", dout1, e.data);
            end
            acks1++;
        end
    end

    // Issue one request. Model rules: line = (addr/32) mod 512; a read returns the
    // stored line, a write stores data and leaves data_o at the last read value;
    // a request presented after edge k is captured at edge k+1 and its ack is
    // visible in the cycle following edge k+LATENCY.
    task automatic do_req(input int w, input logic [31:0] a, input logic wr,
                          input logic [255:0] d, input bit churn, input bit hold);
        int           lat, idx, a0, t;
        logic [255:0] old;
        exp_t         e;
        lat = (w == 0) ? 10 : 1;
        idx = int'((a >> 5) % 512);
        old = ref_mem[w][idx];
        addr  = a;
        write = wr;
        din   = d;
        if (w == 0) en0 = 1'b1; else en1 = 1'b1;
        e.cyc = cyc + lat;
        if (wr) begin
            ref_mem[w][idx] = d;
            e.data = last_rd[w];
        end else begin
            e.data = old;
            last_rd[w] = old;
        end
        a0 = (w == 0) ? acks0 : acks1;
        if (w == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk); #1;
        if (wr && lat > 1) chk("mem_before_ack", dmem(w, idx), old);
        if (churn) begin
            addr  = $urandom;
            din   = rnd256();
            write = 1'($urandom);
            if (w == 0) en0 = 1'b0; else en1 = 1'b0;
        end
        t = 0;
        while (((w == 0) ? acks0 : acks1) == a0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 300) chk_int("ack_timeout", t, 0);
        if (!hold) begin
            if (w == 0) en0 = 1'b0; else en1 = 1'b0;
        end
    endtask

    initial begin
        logic [255:0] v;
        logic [255:0] pat;
        logic [255:0] ecfa;
        int           n;
        rst_n = 1'b0;
        en0 = 1'b0; en1 = 1'b0;
        addr = '0; din = '0; write = 1'b0;
        pat  = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
        ecfa = {16{16'hECFA}};
        for (int i = 0; i < 512; i++) begin
            v = (i == 0) ? pat : rnd256();
            ref_mem[0][i] = v;
            ref_mem[1][i] = v;
            dut0.memory[i] = v;
            dut1.memory[i] = v;
        end
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack0", {255'd0, ack0}, 256'd0);
        chk("reset_dout0", dout0, 256'd0);
        chk("reset_ack1", {255'd0, ack1}, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read of line 0 with the known pattern.
        do_req(0, 32'h0, 1'b0, '0, 1'b0, 1'b0);
        // Write line 2 then read it back.
        do_req(0, 32'h40, 1'b1, ecfa, 1'b0, 1'b0);
        chk("mem2_after_write", dmem(0, 2), ecfa);
        do_req(0, 32'h40, 1'b0, '0, 1'b0, 1'b0);
        // Write-back then refill with enable held.
        v = rnd256();
        do_req(0, 32'h200, 1'b1, v, 1'b0, 1'b1);
        do_req(0, 32'h400, 1'b0, '0, 1'b0, 1'b0);
        chk("mem16_written", dmem(0, 16), v);
        // Input churn during BUSY.
        do_req(0, 32'h20, 1'b0, '0, 1'b1, 1'b0);

        // Reset in the middle of a write to line 18.
        addr = 32'h240; write = 1'b1; din = rnd256(); en0 = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        en0 = 1'b0;
        chk("rst_mid_ack0", {255'd0, ack0}, 256'd0);
        chk("rst_mid_dout0", dout0, 256'd0);
        chk("rst_mid_dout1", dout1, 256'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem18_kept", dmem(0, 18), ref_mem[0][18]);
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(posedge clk); #1;
        do_req(0, 32'h240, 1'b0, '0, 1'b0, 1'b0);

        // LATENCY=1 instance: aliased address.
        do_req(1, 32'h4020, 1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic on both instances.
        for (int i = 0; i < 24; i++) begin
            bit hold;
            hold = (i < 23) ? 1'($urandom) : 1'b0;
            do_req(0, $urandom, 1'($urandom), rnd256(), 1'($urandom), hold);
            if (!hold) begin
                n = $urandom_range(0, 2);
                repeat (n) @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            bit hold;
            hold = (i < 11) ? 1'($urandom) : 1'b0;
            do_req(1, {18'd0, 9'($urandom_range(0, 7)), 5'($urandom)} | ($urandom & 32'hFFFF_C000),
                   1'($urandom), rnd256(), 1'b0, hold);
        end

        repeat (3) @(posedge clk);
        #1;
        chk_int("q0_drained", q0.size(), 0);
        chk_int("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
